// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S DAC transmitter.
//   SAMPLE_W       : audio sample width
//   SLOTS          : bclk slots per stereo frame
//   LEFT_LAST_SLOT : last slot index carrying the left channel
//   state_e        : transmitter control states
package i2s_pkg;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned SLOTS          = 32;
  localparam int unsigned LEFT_LAST_SLOT = 15;
  localparam int unsigned SLOT_W         = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, SHIFT_L, SHIFT_R} state_e;

  // Word select for a slot. Right is flagged one slot early so the channel
  // change leads the first data bit by one bclk (I2S one-bit delay).
  function automatic logic lr_of_slot(logic [SLOT_W-1:0] s);
    return (s >= SLOT_W'(LEFT_LAST_SLOT)) && (s <= SLOT_W'(SLOTS - 2));
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// I2S bit-clock divider.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bclk  : bit clock, toggles every DIV clk cycles, low after reset
//   fall  : one-cycle strobe, high on the cycle whose clk edge drives bclk low
module bclk_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            bclk_q;
  logic            wrap;

  assign wrap = (cnt_q == CntW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

  assign bclk = bclk_q;
  assign fall = wrap & bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Mono-to-stereo I2S transmitter with a one-entry sample buffer.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   sample       : 16-bit two's-complement mono sample
//   sample_valid : sample offered this cycle
//   sample_ready : buffer empty, a sample can be accepted
//   bclk         : I2S bit clock
//   lrclk        : I2S word select (0 left, 1 right)
//   sdata        : I2S serial data, MSB first, changes on bclk falling edge
//   underrun     : one-cycle pulse when a frame starts with no sample buffered
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  logic                fall;
  logic [SLOT_W-1:0]   s_q, s_d;
  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] buf_q, buf_d;
  logic [SAMPLE_W-1:0] frame_q, frame_d;
  logic                full_q, full_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;
  logic                accept;
  logic                load;
  logic [3:0]          bit_idx;

  bclk_gen #(
    .DIV(DIV)
  ) u_bclk_gen (
    .clk  (clk),
    .reset(reset),
    .bclk (bclk),
    .fall (fall)
  );

  assign sample_ready = ~full_q;
  assign accept       = sample_valid & ~full_q;
  // Frame boundary: the fall strobe that wraps the slot counter to 0.
  assign load         = fall & (s_q == SLOT_W'(SLOTS - 1));

  always_comb begin
    s_d        = s_q;
    state_d    = state_q;
    buf_d      = buf_q;
    full_d     = full_q;
    frame_d    = frame_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    bit_idx    = '0;

    if (accept) begin
      buf_d  = sample;
      full_d = 1'b1;
    end

    // accept cannot coincide with a full-buffer load, so the two never collide.
    if (load) begin
      if (full_q) begin
        frame_d = buf_q;
        full_d  = 1'b0;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
    end

    if (fall) begin
      s_d     = (s_q == SLOT_W'(SLOTS - 1)) ? '0 : s_q + SLOT_W'(1);
      lrclk_d = lr_of_slot(s_d);
      // Both channels index the same 16-bit frame: 15-s left, 31-s right.
      bit_idx = 4'(LEFT_LAST_SLOT) - s_d[3:0];
      sdata_d = frame_d[bit_idx];

      unique case (state_q)
        IDLE:    state_d = SHIFT_L;
        SHIFT_L: if (s_q == SLOT_W'(LEFT_LAST_SLOT)) state_d = SHIFT_R;
        SHIFT_R: if (s_q == SLOT_W'(SLOTS - 1)) state_d = SHIFT_L;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q        <= SLOT_W'(SLOTS - 1);
      state_q    <= IDLE;
      buf_q      <= '0;
      frame_q    <= '0;
      full_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      state_q    <= state_d;
      buf_q      <= buf_d;
      frame_q    <= frame_d;
      full_q     <= full_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: instance 0 uses DIV=4, instance 1 uses DIV=2.
// A frame-level reference model predicts every output on every cycle from
// the edge count since reset release; directed sequences cover the corners.
module tb_i2s_dac_tx;

  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        vld     [2];
  logic [15:0] smp     [2];
  logic        rdy     [2];
  logic        bclk_w  [2];
  logic        lrclk_w [2];
  logic        sdata_w [2];
  logic        und_w   [2];

  i2s_dac_tx #(.DIV(D0)) u_dut4 (
    .clk(clk), .reset(rst[0]), .sample(smp[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .bclk(bclk_w[0]), .lrclk(lrclk_w[0]), .sdata(sdata_w[0]),
    .underrun(und_w[0])
  );

  i2s_dac_tx #(.DIV(D1)) u_dut2 (
    .clk(clk), .reset(rst[1]), .sample(smp[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .bclk(bclk_w[1]), .lrclk(lrclk_w[1]), .sdata(sdata_w[1]),
    .underrun(und_w[1])
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, per instance.
  int          m_n     [2];  // clk edges since reset release
  logic        m_full  [2];
  logic [15:0] m_buf   [2];
  logic [15:0] m_frame [2];
  logic        m_und   [2];
  bit          en      [2] = '{1'b0, 1'b0};

  function automatic int div_of(input int i);
    return (i == 0) ? int'(D0) : int'(D1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int d, k;
    logic acc;
    d = div_of(i);
    if (rst[i]) begin
      m_n[i] = 0; m_full[i] = 1'b0; m_buf[i] = '0; m_frame[i] = '0; m_und[i] = 1'b0;
      en[i] = 1'b1;
    end else if (en[i]) begin
      acc = vld[i] && !m_full[i];
      m_n[i]++;
      m_und[i] = 1'b0;
      k = m_n[i] / (2 * d);
      // Frame f starts on fall number 1+32f, i.e. edge 2D + 64D*f.
      if ((m_n[i] % (2 * d) == 0) && ((k - 1) % 32 == 0)) begin
        if (m_full[i]) begin
          m_frame[i] = m_buf[i];
          m_full[i]  = 1'b0;
        end else begin
          m_frame[i] = '0;
          m_und[i]   = 1'b1;
        end
      end
      if (acc) begin
        m_buf[i]  = smp[i];
        m_full[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [4:0] expect_out(input int i);
    int d, k, s;
    logic b, lr, sd;
    d  = div_of(i);
    k  = m_n[i] / (2 * d);
    s  = (k + 31) % 32;
    b  = logic'((m_n[i] / d) % 2);
    lr = (s >= 15) && (s <= 30);
    sd = (s < 16) ? m_frame[i][15 - s] : m_frame[i][31 - s];
    return {b, lr, sd, m_und[i], !m_full[i]};
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Every cycle: {bclk, lrclk, sdata, underrun, sample_ready} against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        chk($sformatf("outs[bclk,lr,sd,und,rdy] div%0d edge%0d", div_of(i), m_n[i]),
            32'({bclk_w[i], lrclk_w[i], sdata_w[i], und_w[i], rdy[i]}),
            32'(expect_out(i)));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timed out");
  end

  task automatic tick(input int m);
    repeat (m) @(negedge clk);
  endtask

  task automatic reset_dut(input int i);
    rst[i] = 1'b1;
    vld[i] = 1'b0;
    tick(2);
    rst[i] = 1'b0;
  endtask

  task automatic wait_n(input int i, input int target);
    int guard;
    guard = 0;
    while (m_n[i] < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (m_n[i] != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_n div%0d: reached edge %0d, required %0d", div_of(i), m_n[i], target);
    end
  endtask

  // DAC view: sdata/lrclk at each bclk rise of the frame loaded at edge fs.
  task automatic capture_frame(input int i, input int fs,
                               output logic [31:0] sd_w, output logic [31:0] lr_w);
    int d;
    d    = div_of(i);
    sd_w = '0;
    lr_w = '0;
    for (int j = 0; j < 32; j++) begin
      wait_n(i, fs + d + 2 * d * j);
      sd_w[31 - j] = sdata_w[i];
      lr_w[31 - j] = lrclk_w[i];
    end
  endtask

  typedef struct {
    string       name;
    int          inst;
    logic [15:0] smp;
    logic [31:0] exp_sd;
    logic [31:0] exp_lr;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] sd_w, lr_w;
  int          q [$];
  int          acc_q [$];
  int          rdy_cnt, und_cnt, sd_cnt;
  logic        prev_b;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; smp[i] = '0;
    end
    tick(3);

    tbl[0] = '{name: "a5c3_div4", inst: 0, smp: 16'hA5C3, exp_sd: 32'hA5C3A5C3,
               exp_lr: 32'h0001FFFE};
    tbl[1] = '{name: "8001_div4", inst: 0, smp: 16'h8001, exp_sd: 32'h80018001,
               exp_lr: 32'h0001FFFE};
    tbl[2] = '{name: "5a3c_div2", inst: 1, smp: 16'h5A3C, exp_sd: 32'h5A3C5A3C,
               exp_lr: 32'h0001FFFE};
    tbl[3] = '{name: "ffff_div2", inst: 1, smp: 16'hFFFF, exp_sd: 32'hFFFFFFFF,
               exp_lr: 32'h0001FFFE};

    // Idle run: underrun at edge 8 and every 256 after, sdata silent.
    reset_dut(0);
    q.delete();
    sd_cnt = 0;
    while (m_n[0] < 600) begin
      @(negedge clk);
      if (und_w[0]) q.push_back(m_n[0]);
      if (sdata_w[0]) sd_cnt++;
    end
    chk("idle underrun count", 32'(q.size()), 32'd3);
    foreach (q[j]) chk($sformatf("idle underrun %0d edge", j), 32'(q[j]), 32'(8 + 256 * j));
    chk("idle sdata high cycles", 32'(sd_cnt), 32'd0);

    // Single sample before the first frame, both channels, lrclk timing.
    for (int t = 0; t < 4; t++) begin
      reset_dut(tbl[t].inst);
      smp[tbl[t].inst] = tbl[t].smp;
      vld[tbl[t].inst] = 1'b1;
      tick(1);
      vld[tbl[t].inst] = 1'b0;
      capture_frame(tbl[t].inst, 2 * div_of(tbl[t].inst), sd_w, lr_w);
      chk({tbl[t].name, " sdata"}, sd_w, tbl[t].exp_sd);
      chk({tbl[t].name, " lrclk"}, lr_w, tbl[t].exp_lr);
    end
    rst[1] = 1'b1;

    // Continuous valid: one ready cycle per frame, no underrun, samples in order.
    reset_dut(0);
    acc_q.delete();
    vld[0] = 1'b1;
    smp[0] = 16'($urandom);
    acc_q.push_back(int'(smp[0]));
    rdy_cnt = 0;
    und_cnt = 0;
    while (m_n[0] < 1032) begin
      @(negedge clk);
      if (m_n[0] >= 9 && rdy[0]) rdy_cnt++;
      if (m_n[0] >= 9 && und_w[0]) und_cnt++;
      smp[0] = 16'($urandom);
      if (rdy[0]) acc_q.push_back(int'(smp[0]));
    end
    chk("stream ready cycles in 4 frames", 32'(rdy_cnt), 32'd4);
    chk("stream underruns", 32'(und_cnt), 32'd0);
    capture_frame(0, 1032, sd_w, lr_w);
    chk("stream frame 4 data", sd_w,
        (acc_q.size() > 4) ? {acc_q[4][15:0], acc_q[4][15:0]} : 32'hXXXX_XXXX);
    vld[0] = 1'b0;

    // Sample offered on the empty-buffer load edge: muted frame, then 0x8000.
    reset_dut(0);
    wait_n(0, 7);
    smp[0] = 16'h8000;
    vld[0] = 1'b1;
    tick(1);
    vld[0] = 1'b0;
    chk("collide underrun", 32'(und_w[0]), 32'd1);
    chk("collide buffered ready", 32'(rdy[0]), 32'd0);
    capture_frame(0, 8, sd_w, lr_w);
    chk("collide frame 0 muted", sd_w, 32'h0);
    capture_frame(0, 264, sd_w, lr_w);
    chk("collide frame 1 data", sd_w, 32'h80008000);

    // Reset at slot 20 with the buffer full.
    reset_dut(0);
    smp[0] = 16'h1234; vld[0] = 1'b1; tick(1); vld[0] = 1'b0;
    wait_n(0, 8);
    smp[0] = 16'hBEEF; vld[0] = 1'b1; tick(1); vld[0] = 1'b0;
    wait_n(0, 170);
    chk("midreset buffer full", 32'(rdy[0]), 32'd0);
    chk("midreset lrclk at s20", 32'(lrclk_w[0]), 32'd1);
    rst[0] = 1'b1;
    tick(1);
    chk("midreset outputs", 32'({bclk_w[0], lrclk_w[0], sdata_w[0], und_w[0], rdy[0]}),
        32'b00001);
    rst[0] = 1'b0;
    wait_n(0, 8);
    chk("midreset next underrun", 32'(und_w[0]), 32'd1);
    capture_frame(0, 8, sd_w, lr_w);
    chk("midreset next frame muted", sd_w, 32'h0);

    // DIV=2 timing: bclk period 4, frame period 128.
    reset_dut(1);
    q.delete();
    acc_q.delete();
    prev_b = 1'b0;
    while (m_n[1] < 300) begin
      @(negedge clk);
      if (bclk_w[1] && !prev_b) q.push_back(m_n[1]);
      if (und_w[1]) acc_q.push_back(m_n[1]);
      prev_b = bclk_w[1];
    end
    chk("div2 first bclk rise", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF, 32'd2);
    for (int j = 1; j < 4 && j < q.size(); j++)
      chk($sformatf("div2 bclk period %0d", j), 32'(q[j] - q[j - 1]), 32'd4);
    chk("div2 underrun count", 32'(acc_q.size()), 32'd3);
    for (int j = 1; j < acc_q.size(); j++)
      chk($sformatf("div2 frame period %0d", j), 32'(acc_q[j] - acc_q[j - 1]), 32'd128);

    // Random traffic: sparse then dense offers, occasional resets.
    for (int i = 0; i < 2; i++) begin
      reset_dut(i);
      for (int c = 0; c < 3000; c++) begin
        vld[i] = (c < 1500) ? ($urandom_range(0, 255) == 0) : ($urandom_range(0, 2) == 0);
        smp[i] = 16'($urandom);
        rst[i] = ($urandom_range(0, 999) == 0);
        tick(1);
      end
      rst[i] = 1'b0;
      vld[i] = 1'b0;
    end
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
